// File: rtl/ati_bus_arbiter_if.sv
// Shared ATI system bus: address/data/type, transfer strobes and the addressed slave's
// flow-control and read-return signals.
interface ati_bus_arbiter_if #(
  parameter int DATA_BUS_WIDTH  = 64,
  parameter int ADDR_BUS_WIDTH  = 64,
  parameter int DATA_TYPE_WIDTH = 2
);
  logic [ADDR_BUS_WIDTH-1:0]  bus_addr;
  logic [DATA_BUS_WIDTH-1:0]  bus_wdata;
  logic [DATA_TYPE_WIDTH-1:0] bus_dtype;
  logic                       bus_wr_req;
  logic                       bus_rd_req;
  logic                       bus_buf_avail;
  logic [DATA_BUS_WIDTH-1:0]  bus_rdata;
  logic                       bus_rdata_valid;

  modport master (
    output bus_addr, bus_wdata, bus_dtype, bus_wr_req, bus_rd_req,
    input  bus_buf_avail, bus_rdata, bus_rdata_valid
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_dtype, bus_wr_req, bus_rd_req,
    output bus_buf_avail, bus_rdata, bus_rdata_valid
  );
endinterface

// File: rtl/ati_bus_arbiter.sv
// Round-robin arbiter sequencing one master transaction at a time onto the shared ATI bus,
// with a bounded wait for read data.
module ati_bus_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int DATA_BUS_WIDTH  = 64,
  parameter int ADDR_BUS_WIDTH  = 64,
  parameter int DATA_TYPE_WIDTH = 2,
  parameter int RD_TIMEOUT      = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_MASTERS-1:0]                 m_req,
  input  logic [NUM_MASTERS-1:0]                 m_we,
  input  logic [NUM_MASTERS*ADDR_BUS_WIDTH-1:0]  m_addr,
  input  logic [NUM_MASTERS*DATA_BUS_WIDTH-1:0]  m_wdata,
  input  logic [NUM_MASTERS*DATA_TYPE_WIDTH-1:0] m_dtype,
  output logic [NUM_MASTERS-1:0]                 m_ack,
  output logic [NUM_MASTERS-1:0]                 m_rvalid,
  output logic [DATA_BUS_WIDTH-1:0]              m_rdata,
  output logic                                   m_rerr,
  output logic                                   busy,
  ati_bus_arbiter_if.master                      bus
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(RD_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    STROBE  = 3'd2,
    WAIT_RD = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                      state_r, next_state_s;
  logic [IDX_W-1:0]            last_grant_r, idx_r, grant_idx_s, cand_s;
  logic                        grant_found_s, rd_done_s, rd_timeout_s, we_r;
  logic [CNT_W-1:0]            rd_cnt_r;
  logic [ADDR_BUS_WIDTH-1:0]   addr_r;
  logic [DATA_BUS_WIDTH-1:0]   wdata_r, rdata_r;
  logic [DATA_TYPE_WIDTH-1:0]  dtype_r;
  logic [NUM_MASTERS-1:0]      ack_r, rvalid_r;
  logic                        rerr_r, wr_req_r, rd_req_r, busy_r;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_MASTERS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first requester at or after last_grant+1, wrapping
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand_s = IDX_W'((int'(last_grant_r) + off) % NUM_MASTERS);
      if (!grant_found_s && m_req[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Next-state logic; valid read data takes precedence over the timeout
  always_comb begin
    next_state_s = state_r;
    rd_done_s    = 1'b0;
    rd_timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_found_s) next_state_s = ISSUE;
        else               next_state_s = IDLE;
      end
      ISSUE: begin
        if (bus.bus_buf_avail) next_state_s = STROBE;
        else                   next_state_s = ISSUE;
      end
      STROBE: begin
        if (we_r) next_state_s = IDLE;
        else      next_state_s = WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.bus_rdata_valid) begin
          rd_done_s    = 1'b1;
          next_state_s = RESP;
        end else if (rd_cnt_r == CNT_W'(RD_TIMEOUT - 1)) begin
          rd_timeout_s = 1'b1;
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT_RD;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Latch the winner's request fields; last_grant resets to the top index so master 0 wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_r <= IDX_W'(NUM_MASTERS - 1);
      idx_r        <= '0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      dtype_r      <= '0;
    end else if (state_r == IDLE && grant_found_s) begin
      last_grant_r <= grant_idx_s;
      idx_r        <= grant_idx_s;
      we_r         <= m_we[grant_idx_s];
      addr_r       <= m_addr[grant_idx_s*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
      wdata_r      <= m_wdata[grant_idx_s*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
      dtype_r      <= m_dtype[grant_idx_s*DATA_TYPE_WIDTH +: DATA_TYPE_WIDTH];
    end
  end

  // Read timeout counter
  always_ff @(posedge clk) begin
    if (!rst_n)                  rd_cnt_r <= '0;
    else if (state_r == STROBE)  rd_cnt_r <= '0;
    else if (state_r == WAIT_RD) rd_cnt_r <= rd_cnt_r + 1'b1;
  end

  // Strobes, pulses and busy are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_r    <= '0;
      rvalid_r <= '0;
      wr_req_r <= 1'b0;
      rd_req_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      ack_r    <= (next_state_s == STROBE) ? onehot(idx_r) : '0;
      rvalid_r <= (next_state_s == RESP)   ? onehot(idx_r) : '0;
      wr_req_r <= (next_state_s == STROBE) &&  we_r;
      rd_req_r <= (next_state_s == STROBE) && !we_r;
      busy_r   <= (next_state_s != IDLE);
    end
  end

  // Read response data/error, held until the next response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_r <= '0;
      rerr_r  <= 1'b0;
    end else if (rd_done_s) begin
      rdata_r <= bus.bus_rdata;
      rerr_r  <= 1'b0;
    end else if (rd_timeout_s) begin
      rdata_r <= '0;
      rerr_r  <= 1'b1;
    end
  end

  assign m_ack          = ack_r;
  assign m_rvalid       = rvalid_r;
  assign m_rdata        = rdata_r;
  assign m_rerr         = rerr_r;
  assign busy           = busy_r;
  assign bus.bus_addr   = addr_r;
  assign bus.bus_wdata  = wdata_r;
  assign bus.bus_dtype  = dtype_r;
  assign bus.bus_wr_req = wr_req_r;
  assign bus.bus_rd_req = rd_req_r;
endmodule

// File: tb/tb_ati_bus_arbiter.sv
// Bench for ati_bus_arbiter: a cycle-arithmetic transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ati_bus_arbiter;
  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_req, m_we, m_ack, m_rvalid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*TW-1:0] m_dtype;
  logic [DW-1:0]   m_rdata;
  logic            m_rerr, busy;

  int n_tests = 0;
  int n_fail  = 0;

  ati_bus_arbiter_if #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .DATA_TYPE_WIDTH(TW)) bus_if ();

  ati_bus_arbiter #(
    .NUM_MASTERS(N), .DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW),
    .DATA_TYPE_WIDTH(TW), .RD_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_dtype(m_dtype), .m_ack(m_ack), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .m_rerr(m_rerr), .busy(busy), .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: cycle c is the clock period in which the negedge falls; inputs are stable there.
  logic [N-1:0]  e_ack = '0, e_rv = '0;
  logic          e_wr = 1'b0, e_rd = 1'b0, e_busy = 1'b0, e_rerr = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_rdata = '0;
  logic [TW-1:0] e_dtype = '0;

  initial begin
    int c, last, idx, t_strobe, t_resp;
    bit chk_on, txn, we;
    c = 0; last = N - 1; idx = 0; t_strobe = -1; t_resp = -1;
    chk_on = 1'b0; txn = 1'b0; we = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      if (chk_on) begin
        check("busy",       {63'd0, busy},              {63'd0, e_busy});
        check("m_ack",      {62'd0, m_ack},             {62'd0, e_ack});
        check("m_rvalid",   {62'd0, m_rvalid},          {62'd0, e_rv});
        check("bus_wr_req", {63'd0, bus_if.bus_wr_req}, {63'd0, e_wr});
        check("bus_rd_req", {63'd0, bus_if.bus_rd_req}, {63'd0, e_rd});
        check("bus_addr",   bus_if.bus_addr,            e_addr);
        check("bus_wdata",  bus_if.bus_wdata,           e_wdata);
        check("bus_dtype",  {62'd0, bus_if.bus_dtype},  {62'd0, e_dtype});
        check("m_rdata",    m_rdata,                    e_rdata);
        check("m_rerr",     {63'd0, m_rerr},            {63'd0, e_rerr});
      end
      if (!rst_n) begin
        chk_on = 1'b1; txn = 1'b0; last = N - 1;
        e_addr = '0; e_wdata = '0; e_dtype = '0; e_rdata = '0; e_rerr = 1'b0;
      end else if (!txn) begin
        for (int k = 1; k <= N; k++) begin
          if (!txn && m_req[(last + k) % N]) begin
            idx = (last + k) % N;
            txn = 1'b1;
          end
        end
        if (txn) begin
          last = idx; we = m_we[idx]; t_strobe = -1; t_resp = -1;
          e_addr  = m_addr[idx*AW +: AW];
          e_wdata = m_wdata[idx*DW +: DW];
          e_dtype = m_dtype[idx*TW +: TW];
        end
      end else if (t_strobe < 0) begin
        if (bus_if.bus_buf_avail) t_strobe = c + 1;
      end else if (c == t_strobe) begin
        if (we) txn = 1'b0;
      end else if (t_resp < 0) begin
        if (bus_if.bus_rdata_valid) begin
          e_rdata = bus_if.bus_rdata; e_rerr = 1'b0; t_resp = c + 1;
        end else if (c - t_strobe == TO) begin
          e_rdata = '0; e_rerr = 1'b1; t_resp = c + 1;
        end
      end else begin
        txn = 1'b0;
      end
      e_ack = '0; e_rv = '0;
      e_busy = rst_n && txn;
      e_wr = rst_n && txn && (t_strobe == c + 1) && we;
      e_rd = rst_n && txn && (t_strobe == c + 1) && !we;
      if (e_wr || e_rd) e_ack[idx] = 1'b1;
      if (rst_n && txn && t_resp == c + 1) e_rv[idx] = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a request and hold it until acked; returns one cycle after the ack cycle
  task automatic issue(input int i, input bit we, input logic [63:0] a,
                       input logic [63:0] d, input logic [1:0] t);
    int n;
    m_req[i] = 1'b1; m_we[i] = we;
    m_addr[i*AW +: AW] = a; m_wdata[i*DW +: DW] = d; m_dtype[i*TW +: TW] = t;
    n = 0;
    do begin @(negedge clk); n++; end while (m_ack[i] !== 1'b1 && n < 200);
    if (m_ack[i] !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout master %0d: no m_ack within %0d cycles", i, n);
    end
    @(posedge clk); #1;
    m_req[i] = 1'b0;
  endtask

  initial begin
    logic [N-1:0] acks [12];
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] acks [12];
    rst_n = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_dtype = '0;
    bus_if.bus_buf_avail = 1'b1; bus_if.bus_rdata = '0; bus_if.bus_rdata_valid = 1'b0;
    step(3);
    @(negedge clk);
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_addr",  bus_if.bus_addr, 64'd0);
    check("rst_ack",   {62'd0, m_ack}, 64'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // T1: single write from master 0
    m_req[0] = 1'b1; m_we[0] = 1'b1;
    m_addr[0 +: AW] = 64'h4000_0000_0000_0010; m_wdata[0 +: DW] = 64'hA5; m_dtype[0 +: TW] = 2'd2;
    @(negedge clk);
    @(negedge clk);
    check("t1_busy_c1", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("t1_wr_req_c2", {63'd0, bus_if.bus_wr_req}, 64'd1);
    check("t1_addr_c2",   bus_if.bus_addr, 64'h4000_0000_0000_0010);
    check("t1_wdata_c2",  bus_if.bus_wdata, 64'hA5);
    check("t1_ack_c2",    {62'd0, m_ack}, 64'd1);
    @(posedge clk); #1;
    m_req[0] = 1'b0;
    @(negedge clk);
    check("t1_busy_c3", {63'd0, busy}, 64'd0);
    step(1);

    // T2: both masters hold write requests; grants alternate starting with master 1
    m_addr[0 +: AW]  = 64'h0000_0000_0000_1000; m_wdata[0 +: DW]  = 64'h11;
    m_addr[AW +: AW] = 64'h8000_0000_0000_2000; m_wdata[DW +: DW] = 64'h22;
    m_we = 2'b11; m_req = 2'b11;
    for (int k = 0; k < 12; k++) begin @(negedge clk); acks[k] = m_ack; end
    @(posedge clk); #1;
    m_req = 2'b00;
    check("t2_ack_c2",  {62'd0, acks[2]},  64'd2);
    check("t2_ack_c5",  {62'd0, acks[5]},  64'd1);
    check("t2_ack_c8",  {62'd0, acks[8]},  64'd2);
    check("t2_ack_c11", {62'd0, acks[11]}, 64'd1);
    check("t2_ack_c3",  {62'd0, acks[3]},  64'd0);
    step(2);

    // T3: slave not ready for 5 cycles
    bus_if.bus_buf_avail = 1'b0;
    m_req[0] = 1'b1; m_we[0] = 1'b1; m_addr[0 +: AW] = 64'h4000_0000_0000_0300;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        check("t3_stall_wr", {63'd0, bus_if.bus_wr_req}, 64'd0);
        check("t3_stall_addr", bus_if.bus_addr, 64'h4000_0000_0000_0300);
      end
      @(posedge clk); #1;
    end
    bus_if.bus_buf_avail = 1'b1;
    @(negedge clk);
    check("t3_wr_c6", {63'd0, bus_if.bus_wr_req}, 64'd0);
    @(negedge clk);
    check("t3_wr_c7",  {63'd0, bus_if.bus_wr_req}, 64'd1);
    check("t3_ack_c7", {62'd0, m_ack}, 64'd1);
    @(posedge clk); #1;
    m_req[0] = 1'b0;
    step(2);

    // T4: read by master 1, data 3 cycles after bus_rd_req
    issue(1, 1'b0, 64'hC000_0000_0000_0100, 64'h0, 2'd2);
    step(2);
    bus_if.bus_rdata_valid = 1'b1; bus_if.bus_rdata = 64'hDEAD_BEEF;
    step(1);
    bus_if.bus_rdata_valid = 1'b0; bus_if.bus_rdata = '0;
    @(negedge clk);
    check("t4_rvalid", {62'd0, m_rvalid}, 64'd2);
    check("t4_rdata",  m_rdata, 64'hDEAD_BEEF);
    check("t4_rerr",   {63'd0, m_rerr}, 64'd0);
    step(2);

    // T5a: read with no response -> timeout error
    issue(0, 1'b0, 64'h4000_0000_0000_0500, 64'h0, 2'd1);
    step(TO);
    @(negedge clk);
    check("t5_to_rvalid", {62'd0, m_rvalid}, 64'd1);
    check("t5_to_rerr",   {63'd0, m_rerr}, 64'd1);
    check("t5_to_rdata",  m_rdata, 64'd0);
    step(2);

    // T5b: data arrives on the last wait cycle -> data wins
    issue(0, 1'b0, 64'h4000_0000_0000_0600, 64'h0, 2'd0);
    step(TO - 1);
    bus_if.bus_rdata_valid = 1'b1; bus_if.bus_rdata = 64'h1234_5678;
    step(1);
    bus_if.bus_rdata_valid = 1'b0; bus_if.bus_rdata = '0;
    @(negedge clk);
    check("t5_last_rvalid", {62'd0, m_rvalid}, 64'd1);
    check("t5_last_rerr",   {63'd0, m_rerr}, 64'd0);
    check("t5_last_rdata",  m_rdata, 64'h1234_5678);
    step(2);

    // T6: reset while waiting for read data; stale valid afterwards is ignored
    issue(1, 1'b0, 64'hC000_0000_0000_0700, 64'h0, 2'd2);
    step(2);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    bus_if.bus_rdata_valid = 1'b1; bus_if.bus_rdata = 64'hFFFF;
    step(1);
    bus_if.bus_rdata_valid = 1'b0; bus_if.bus_rdata = '0;
    @(negedge clk);
    check("t6_no_rvalid", {62'd0, m_rvalid}, 64'd0);
    check("t6_idle",      {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    m_we = 2'b11; m_req = 2'b11;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t6_first_grant", {62'd0, m_ack}, 64'd1);
    @(posedge clk); #1;
    m_req = 2'b00;
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
